// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
//   arbStateT : transaction sequencer states
//   srcT      : which requester owns the port (I-refill, D-line, uncached IO)
//   GNT_*     : bit positions of each requester in request/grant vectors
//   LEN_LINE / LEN_SINGLE : io_MemLen encodings (beats - 1)
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StWack,
    StRdata
  } arbStateT;

  typedef enum logic [1:0] {
    SRC_I  = 2'd0,
    SRC_D  = 2'd1,
    SRC_IO = 2'd2
  } srcT;

  localparam int unsigned GNT_I  = 0;
  localparam int unsigned GNT_D  = 1;
  localparam int unsigned GNT_IO = 2;

  localparam int unsigned BURST_LEN_DEF = 4;

  // io_MemLen is two bits wide, so a line is at most four beats.
  function automatic logic [1:0] lineLen(int unsigned burstLen);
    return 2'(burstLen - 1);
  endfunction

  localparam logic [1:0] LEN_LINE   = lineLen(BURST_LEN_DEF);
  localparam logic [1:0] LEN_SINGLE = 2'd0;

endpackage

// File: rtl/mem_port_pick.sv
// Combinational requester picker for the memory port.
//   reqs  : {IO, D, I} request vector (positions GNT_IO/GNT_D/GNT_I)
//   ptr   : round-robin pointer, 1 = D wins an I/D tie, 0 = I wins
//   grant : one-hot grant, all zero when nothing is requested
// IO always wins; I and D share the port by the round-robin pointer.
module mem_port_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] reqs,
  input  logic       ptr,
  output logic [2:0] grant
);

  always_comb begin
    grant = '0;
    if (reqs[GNT_IO]) begin
      grant[GNT_IO] = 1'b1;
    end else if (reqs[GNT_I] && reqs[GNT_D]) begin
      if (ptr) begin
        grant[GNT_D] = 1'b1;
      end else begin
        grant[GNT_I] = 1'b1;
      end
    end else if (reqs[GNT_D]) begin
      grant[GNT_D] = 1'b1;
    end else if (reqs[GNT_I]) begin
      grant[GNT_I] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between I-cache refill, D-cache
// refill/write-back and the uncached IO path.
//   clock, reset        : single clock, synchronous active-high reset
//   io_I*               : I-refill request/address, beat-valid and done
//   io_D*               : D refill/write-back request, write beat handshake,
//                         beat-valid and done
//   io_Io*              : uncached load/store request and done
//   io_RData            : shared read return (io_MemRdata passed through)
//   io_Mem*             : external port (address, write-data, read-data, ack)
//   io_ImissVld, io_DmissVld, io_IoBlk : pipeline freeze hints
// Each grant is sequenced Idle -> Addr -> (Wdata -> Wack | Rdata) -> Idle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_IReq,
  input  logic [ADDR_W-1:0] io_IAddr,
  output logic              io_IBeatVld,
  output logic              io_IDone,
  input  logic              io_DReq,
  input  logic              io_DWr,
  input  logic [ADDR_W-1:0] io_DAddr,
  input  logic [DATA_W-1:0] io_DWdata,
  output logic              io_DWdataRdy,
  output logic              io_DBeatVld,
  output logic              io_DDone,
  input  logic              io_IoReq,
  input  logic              io_IoWr,
  input  logic [ADDR_W-1:0] io_IoAddr,
  input  logic [DATA_W-1:0] io_IoWdata,
  output logic              io_IoDone,
  output logic [DATA_W-1:0] io_RData,
  output logic              io_MemReqVld,
  input  logic              io_MemReqRdy,
  output logic [ADDR_W-1:0] io_MemAddr,
  output logic              io_MemWr,
  output logic [1:0]        io_MemLen,
  output logic              io_MemWdataVld,
  input  logic              io_MemWdataRdy,
  output logic [DATA_W-1:0] io_MemWdata,
  input  logic              io_MemRdataVld,
  input  logic [DATA_W-1:0] io_MemRdata,
  input  logic              io_MemWrAck,
  output logic              io_ImissVld,
  output logic              io_DmissVld,
  output logic              io_IoBlk
);

  localparam logic [1:0] LenLine = lineLen(BURST_LEN);

  arbStateT          stateQ, stateD;
  srcT               srcQ, srcD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic              wrQ, wrD;
  logic [1:0]        lenQ, lenD;
  logic [1:0]        cntQ, cntD;
  logic              rrQ, rrD;     // 1 = D wins the next I/D tie

  logic [2:0] grant;
  logic       rdBeat, wrBeat, lastBeat, ackHit, done;

  mem_port_pick uPick (
    .reqs  ({io_IoReq, io_DReq, io_IReq}),
    .ptr   (rrQ),
    .grant (grant)
  );

  assign lastBeat = (cntQ == lenQ);
  assign rdBeat   = (stateQ == StRdata) && io_MemRdataVld;
  assign wrBeat   = (stateQ == StWdata) && io_MemWdataRdy;
  assign ackHit   = (stateQ == StWack) && io_MemWrAck;
  assign done     = (rdBeat && lastBeat) || ackHit;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (|grant) stateD = StAddr;
      StAddr:  if (io_MemReqRdy) stateD = wrQ ? StWdata : StRdata;
      StWdata: if (wrBeat && lastBeat) stateD = StWack;
      StWack:  if (io_MemWrAck) stateD = StIdle;
      StRdata: if (rdBeat && lastBeat) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    io_MemReqVld   = (stateQ == StAddr);
    io_MemWdataVld = (stateQ == StWdata);
    io_MemWdata    = '0;
    if (stateQ == StWdata) begin
      io_MemWdata = (srcQ == SRC_D) ? io_DWdata : io_IoWdata;
    end
    io_IBeatVld  = rdBeat && (srcQ == SRC_I);
    io_DBeatVld  = rdBeat && (srcQ == SRC_D);
    io_DWdataRdy = wrBeat && (srcQ == SRC_D);
    io_IDone     = done && (srcQ == SRC_I);
    io_DDone     = done && (srcQ == SRC_D);
    io_IoDone    = done && (srcQ == SRC_IO);
  end

  // Transaction payload, beat counter and round-robin pointer
  always_comb begin
    srcD  = srcQ;
    addrD = addrQ;
    wrD   = wrQ;
    lenD  = lenQ;
    cntD  = cntQ;
    rrD   = rrQ;
    if (stateQ == StIdle) begin
      if (grant[GNT_IO]) begin
        srcD  = SRC_IO;
        addrD = io_IoAddr;
        wrD   = io_IoWr;
        lenD  = LEN_SINGLE;
      end else if (grant[GNT_D]) begin
        srcD  = SRC_D;
        addrD = io_DAddr;
        wrD   = io_DWr;
        lenD  = LenLine;
        rrD   = 1'b0;
      end else if (grant[GNT_I]) begin
        srcD  = SRC_I;
        addrD = io_IAddr;
        wrD   = 1'b0;
        lenD  = LenLine;
        rrD   = 1'b1;
      end
    end
    if ((stateQ == StAddr) && io_MemReqRdy) begin
      cntD = '0;
    end else if (rdBeat || wrBeat) begin
      cntD = cntQ + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      srcQ  <= SRC_I;
      addrQ <= '0;
      wrQ   <= 1'b0;
      lenQ  <= '0;
      cntQ  <= '0;
      rrQ   <= 1'b1;
    end else begin
      srcQ  <= srcD;
      addrQ <= addrD;
      wrQ   <= wrD;
      lenQ  <= lenD;
      cntQ  <= cntD;
      rrQ   <= rrD;
    end
  end

  assign io_MemAddr = addrQ;
  assign io_MemWr   = wrQ;
  assign io_MemLen  = lenQ;
  assign io_RData   = io_MemRdata;

  assign io_ImissVld = io_IReq & ~io_IDone;
  assign io_DmissVld = io_DReq & ~io_DDone;
  assign io_IoBlk    = io_IoReq & ~io_IoDone;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_IReq, io_IBeatVld, io_IDone;
  logic [AW-1:0] io_IAddr;
  logic          io_DReq, io_DWr, io_DWdataRdy, io_DBeatVld, io_DDone;
  logic [AW-1:0] io_DAddr;
  logic [DW-1:0] io_DWdata;
  logic          io_IoReq, io_IoWr, io_IoDone;
  logic [AW-1:0] io_IoAddr;
  logic [DW-1:0] io_IoWdata, io_RData;
  logic          io_MemReqVld, io_MemReqRdy, io_MemWr;
  logic [AW-1:0] io_MemAddr;
  logic [1:0]    io_MemLen;
  logic          io_MemWdataVld, io_MemWdataRdy, io_MemRdataVld, io_MemWrAck;
  logic [DW-1:0] io_MemWdata, io_MemRdata;
  logic          io_ImissVld, io_DmissVld, io_IoBlk;

  int nCmp  = 0;
  int nFail = 0;
  bit modelRrD;  // reference pointer: 1 means D wins an I/D tie

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4)) dut (
    .clock(clock), .reset(reset),
    .io_IReq(io_IReq), .io_IAddr(io_IAddr), .io_IBeatVld(io_IBeatVld), .io_IDone(io_IDone),
    .io_DReq(io_DReq), .io_DWr(io_DWr), .io_DAddr(io_DAddr), .io_DWdata(io_DWdata),
    .io_DWdataRdy(io_DWdataRdy), .io_DBeatVld(io_DBeatVld), .io_DDone(io_DDone),
    .io_IoReq(io_IoReq), .io_IoWr(io_IoWr), .io_IoAddr(io_IoAddr), .io_IoWdata(io_IoWdata),
    .io_IoDone(io_IoDone), .io_RData(io_RData),
    .io_MemReqVld(io_MemReqVld), .io_MemReqRdy(io_MemReqRdy), .io_MemAddr(io_MemAddr),
    .io_MemWr(io_MemWr), .io_MemLen(io_MemLen), .io_MemWdataVld(io_MemWdataVld),
    .io_MemWdataRdy(io_MemWdataRdy), .io_MemWdata(io_MemWdata),
    .io_MemRdataVld(io_MemRdataVld), .io_MemRdata(io_MemRdata), .io_MemWrAck(io_MemWrAck),
    .io_ImissVld(io_ImissVld), .io_DmissVld(io_DmissVld), .io_IoBlk(io_IoBlk)
  );

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    io_IReq = 0; io_IAddr = '0; io_DReq = 0; io_DWr = 0; io_DAddr = '0; io_DWdata = '0;
    io_IoReq = 0; io_IoWr = 0; io_IoAddr = '0; io_IoWdata = '0;
    io_MemReqRdy = 0; io_MemWdataRdy = 0; io_MemRdataVld = 0; io_MemRdata = '0;
    io_MemWrAck = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
    modelRrD = 1'b1;
    #1;
  endtask

  function automatic logic [16:0] ctl_outs();
    return {io_IBeatVld, io_IDone, io_DWdataRdy, io_DBeatVld, io_DDone, io_IoDone,
            io_MemReqVld, io_MemWr, io_MemLen, io_MemWdataVld, io_ImissVld, io_DmissVld,
            io_IoBlk, io_MemAddr[1:0], io_MemWdata[0]};
  endfunction

  task automatic test_reset();
    apply_reset();
    nCmp++; if (ctl_outs() !== '0) begin
      nFail++; $display("FAIL reset_ctl got=%b want=0", ctl_outs()); end
    nCmp++; if (io_MemAddr !== '0) begin
      nFail++; $display("FAIL reset_addr got=%h want=0", io_MemAddr); end
    nCmp++; if (io_MemWdata !== '0) begin
      nFail++; $display("FAIL reset_wdata got=%h want=0", io_MemWdata); end
    nCmp++; if (io_RData !== '0) begin
      nFail++; $display("FAIL reset_rdata got=%h want=0", io_RData); end
  endtask

  task automatic test_i_refill();
    logic [DW-1:0] d;
    apply_reset();
    io_IReq = 1; io_IAddr = 32'h1000; io_MemReqRdy = 1; #1;
    nCmp++; if ({io_MemReqVld, io_ImissVld} !== 2'b01) begin
      nFail++; $display("FAIL irefill_pre vld/miss got=%b want=01", {io_MemReqVld, io_ImissVld}); end
    cyc();
    nCmp++; if ({io_MemReqVld, io_MemAddr, io_MemLen, io_MemWr} !== {1'b1, 32'h1000, 2'd3, 1'b0})
      begin nFail++; $display("FAIL irefill_addr got=%b/%h/%0d/%b want=1/1000/3/0",
        io_MemReqVld, io_MemAddr, io_MemLen, io_MemWr); end
    cyc();
    io_MemReqRdy = 0;
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom};
      io_MemRdataVld = 1; io_MemRdata = d; #1;
      nCmp++; if ({io_IBeatVld, io_DBeatVld, io_IDone, io_RData} !== {2'b10, b == 3, d}) begin
        nFail++; $display("FAIL irefill_beat%0d ibv/dbv/done=%b%b%b rdata=%h want=1/0/%0d %h",
          b, io_IBeatVld, io_DBeatVld, io_IDone, io_RData, b == 3, d); end
      cyc();
    end
    io_MemRdataVld = 0; io_IReq = 0; #1;
    nCmp++; if ({io_ImissVld, io_IDone, io_MemReqVld} !== 3'b000) begin
      nFail++; $display("FAIL irefill_after miss/done/vld got=%b want=000",
        {io_ImissVld, io_IDone, io_MemReqVld}); end
    cyc();
    nCmp++; if (io_MemReqVld !== 1'b0) begin
      nFail++; $display("FAIL irefill_nogrant got=%b want=0", io_MemReqVld); end
  endtask

  // One round of traffic: the selected requesters raise together and each is
  // served to completion; the expected grant order comes from the priority rules.
  task automatic test_traffic(input logic [2:0] mask);
    int            order[$];
    logic [2:0]    pend;
    logic [AW-1:0] addrOf[3];
    logic          wrOf[3];
    logic [1:0]    lenOf[3];
    logic [DW-1:0] dLine[4];
    logic [DW-1:0] ioData;
    int            s, n, b, dly;
    logic [2:0]    doneV, missV;
    logic [1:0]    beatV;
    logic          v, rdy;
    logic [DW-1:0] d, wexp;
    for (int i = 0; i < 3; i++) addrOf[i] = $urandom & 32'hFFFF_FFE0;
    wrOf[0] = 0; wrOf[1] = 1'($urandom % 2); wrOf[2] = 1'($urandom % 2);
    lenOf[0] = 2'd3; lenOf[1] = 2'd3; lenOf[2] = 2'd0;
    for (int i = 0; i < 4; i++) dLine[i] = {$urandom, $urandom};
    ioData = {$urandom, $urandom};
    pend = mask;
    while (pend != 0) begin
      if (pend[2]) s = 2;
      else if (pend[0] && pend[1]) s = modelRrD ? 1 : 0;
      else s = pend[0] ? 0 : 1;
      order.push_back(s);
      pend[s] = 1'b0;
      if (s != 2) modelRrD = (s == 0);
    end
    io_IReq = mask[0]; io_IAddr = addrOf[0];
    io_DReq = mask[1]; io_DAddr = addrOf[1]; io_DWr = wrOf[1];
    io_IoReq = mask[2]; io_IoAddr = addrOf[2]; io_IoWr = wrOf[2]; io_IoWdata = ioData;
    #1;
    foreach (order[k]) begin
      s = order[k];
      n = 0;
      while (io_MemReqVld !== 1'b1 && n < 10) begin cyc(); n++; end
      nCmp++; if (n !== 1) begin
        nFail++; $display("FAIL traffic_grant_latency src=%0d got=%0d want=1", s, n);
        if (io_MemReqVld !== 1'b1) begin apply_reset(); return; end
      end
      missV = {io_IoBlk, io_DmissVld, io_ImissVld};
      nCmp++; if ({io_MemAddr, io_MemWr, io_MemLen, missV[s]} !==
                  {addrOf[s], wrOf[s], lenOf[s], 1'b1}) begin
        nFail++; $display("FAIL traffic_addr src=%0d got=%h/%b/%0d miss=%b want=%h/%b/%0d/1",
          s, io_MemAddr, io_MemWr, io_MemLen, missV[s], addrOf[s], wrOf[s], lenOf[s]); end
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) begin
        cyc();
        nCmp++; if ({io_MemReqVld, io_MemAddr, io_MemLen} !== {1'b1, addrOf[s], lenOf[s]}) begin
          nFail++; $display("FAIL traffic_stall src=%0d vld=%b addr=%h", s, io_MemReqVld,
            io_MemAddr); end
      end
      io_MemReqRdy = 1; cyc(); io_MemReqRdy = 0;
      b = 0; n = 0;
      if (!wrOf[s]) begin
        while (b <= int'(lenOf[s]) && n < 40) begin
          v = ($urandom_range(0, 2) != 0);
          d = {$urandom, $urandom};
          io_MemRdataVld = v; io_MemRdata = d; io_MemWrAck = 1'($urandom % 2); #1;
          beatV = (v && s != 2) ? 2'(1 << s) : 2'b00;
          doneV = {io_IoDone, io_DDone, io_IDone};
          missV = {io_IoBlk, io_DmissVld, io_ImissVld};
          nCmp++; if ({io_DBeatVld, io_IBeatVld} !== beatV || doneV !== ((v && b == int'(lenOf[s]))
              ? 3'(1 << s) : 3'b000) || (v && io_RData !== d)) begin
            nFail++; $display("FAIL traffic_rd src=%0d beat=%0d bv=%b done=%b rdata=%h want=%b %h",
              s, b, {io_DBeatVld, io_IBeatVld}, doneV, io_RData, beatV, d); end
          if (v && b == int'(lenOf[s])) begin
            nCmp++; if (missV[s] !== 1'b0) begin
              nFail++; $display("FAIL traffic_miss_at_done src=%0d got=1 want=0", s); end
          end
          if (v) b++;
          cyc(); n++;
        end
      end else begin
        while (b <= int'(lenOf[s]) && n < 40) begin
          rdy = 1'($urandom % 2);
          io_MemWdataRdy = rdy; io_DWdata = dLine[b];
          io_MemRdataVld = 1'($urandom % 2); io_MemWrAck = 1'($urandom % 2); #1;
          wexp = (s == 1) ? dLine[b] : ioData;
          doneV = {io_IoDone, io_DDone, io_IDone};
          nCmp++; if ({io_MemWdataVld, io_MemWdata, io_DWdataRdy, doneV, io_IBeatVld,
                       io_DBeatVld} !== {1'b1, wexp, rdy && s == 1, 5'b0}) begin
            nFail++; $display("FAIL traffic_wr src=%0d beat=%0d vld=%b wd=%h drdy=%b done=%b want %h",
              s, b, io_MemWdataVld, io_MemWdata, io_DWdataRdy, doneV, wexp); end
          if (rdy) b++;
          cyc(); n++;
        end
        io_MemWdataRdy = 0; io_MemRdataVld = 0;
        dly = $urandom_range(0, 3);
        for (int i = 0; i < dly; i++) begin
          io_MemWrAck = 0; #1;
          nCmp++; if ({io_MemWdataVld, io_IoDone, io_DDone, io_IDone} !== 4'b0) begin
            nFail++; $display("FAIL traffic_wack_wait src=%0d got=%b want=0", s,
              {io_MemWdataVld, io_IoDone, io_DDone, io_IDone}); end
          cyc();
        end
        io_MemWrAck = 1; #1;
        doneV = {io_IoDone, io_DDone, io_IDone};
        nCmp++; if (doneV !== 3'(1 << s)) begin
          nFail++; $display("FAIL traffic_wack src=%0d done=%b want=%b", s, doneV, 3'(1 << s)); end
        cyc();
      end
      nCmp++; if (n >= 40) begin nFail++; $display("FAIL traffic_timeout src=%0d", s); end
      io_MemRdataVld = 0; io_MemWrAck = 0;
      case (s)
        0: io_IReq = 0;
        1: io_DReq = 0;
        default: io_IoReq = 0;
      endcase
      #1;
      missV = {io_IoBlk, io_DmissVld, io_ImissVld};
      nCmp++; if ({missV[s], io_IoDone, io_DDone, io_IDone} !== 4'b0) begin
        nFail++; $display("FAIL traffic_after src=%0d miss/done=%b want=0", s,
          {missV[s], io_IoDone, io_DDone, io_IDone}); end
    end
  endtask

  task automatic test_alternation();
    apply_reset();
    test_traffic(3'b011);
    test_traffic(3'b011);
  endtask

  task automatic test_d_writeback();
    logic [DW-1:0] line[4];
    logic [4:0]    pat = 5'b11101;  // beat-ready pattern 1,0,1,1,1 (LSB first)
    int            b = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) line[i] = {$urandom, $urandom};
    io_DReq = 1; io_DWr = 1; io_DAddr = 32'h2040; io_MemReqRdy = 1; #1;
    cyc();
    nCmp++; if ({io_MemReqVld, io_MemAddr, io_MemWr, io_MemLen} !== {1'b1, 32'h2040, 1'b1, 2'd3})
      begin nFail++; $display("FAIL dwb_addr got=%b/%h/%b/%0d", io_MemReqVld, io_MemAddr,
        io_MemWr, io_MemLen); end
    cyc();
    io_MemReqRdy = 0;
    for (int i = 0; i < 5; i++) begin
      io_MemWdataRdy = pat[i]; io_DWdata = line[b]; #1;
      nCmp++; if ({io_MemWdataVld, io_DWdataRdy, io_MemWdata} !== {1'b1, pat[i], line[b]}) begin
        nFail++; $display("FAIL dwb_beat%0d vld=%b drdy=%b wd=%h want 1/%b/%h", i,
          io_MemWdataVld, io_DWdataRdy, io_MemWdata, pat[i], line[b]); end
      if (pat[i]) b++;
      cyc();
    end
    io_MemWdataRdy = 1; #1;
    for (int i = 0; i < 2; i++) begin
      nCmp++; if ({io_MemWdataVld, io_DWdataRdy, io_DDone} !== 3'b000) begin
        nFail++; $display("FAIL dwb_wack_wait%0d got=%b want=000", i,
          {io_MemWdataVld, io_DWdataRdy, io_DDone}); end
      cyc();
    end
    io_MemWdataRdy = 0; io_MemWrAck = 1; #1;
    nCmp++; if ({io_DDone, io_DmissVld} !== 2'b10) begin
      nFail++; $display("FAIL dwb_done done/miss got=%b want=10", {io_DDone, io_DmissVld}); end
    cyc();
    io_MemWrAck = 0; io_DReq = 0; #1;
    nCmp++; if ({io_DDone, io_DmissVld, io_MemReqVld} !== 3'b000) begin
      nFail++; $display("FAIL dwb_after got=%b want=000", {io_DDone, io_DmissVld, io_MemReqVld}); end
  endtask

  task automatic test_io_priority();
    apply_reset();
    test_traffic(3'b110);
    test_traffic(3'b111);
  endtask

  task automatic test_req_stall();
    apply_reset();
    io_IReq = 1; io_IAddr = 32'hABC0; #1;
    cyc();
    io_MemRdataVld = 1; io_MemWrAck = 1; #1;
    for (int i = 0; i < 5; i++) begin
      nCmp++; if ({io_MemReqVld, io_MemAddr, io_MemLen, io_IDone, io_IBeatVld} !==
                  {1'b1, 32'hABC0, 2'd3, 2'b00}) begin
        nFail++; $display("FAIL stall%0d vld=%b addr=%h len=%0d done=%b bv=%b", i, io_MemReqVld,
          io_MemAddr, io_MemLen, io_IDone, io_IBeatVld); end
      cyc();
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    io_DReq = 1; io_DWr = 0; io_DAddr = 32'h3000; io_MemReqRdy = 1; #1;
    cyc(); cyc();
    io_MemReqRdy = 0;
    for (int b = 0; b < 2; b++) begin
      io_MemRdataVld = 1; io_MemRdata = {$urandom, $urandom}; #1;
      nCmp++; if ({io_DBeatVld, io_DDone} !== 2'b10) begin
        nFail++; $display("FAIL rstmid_beat%0d got=%b want=10", b, {io_DBeatVld, io_DDone}); end
      cyc();
    end
    reset = 1; idle_inputs();
    cyc();
    reset = 0; modelRrD = 1'b1; #1;
    nCmp++; if (ctl_outs() !== '0 || io_MemAddr !== '0 || io_RData !== '0) begin
      nFail++; $display("FAIL rstmid_outs ctl=%b addr=%h", ctl_outs(), io_MemAddr); end
    io_MemRdataVld = 1; #1;
    nCmp++; if ({io_DBeatVld, io_IBeatVld, io_DDone, io_IDone, io_IoDone} !== 5'b0) begin
      nFail++; $display("FAIL rstmid_stray got=%b want=0",
        {io_DBeatVld, io_IBeatVld, io_DDone, io_IDone, io_IoDone}); end
    cyc();
    io_MemRdataVld = 0; #1;
    nCmp++; if (io_MemReqVld !== 1'b0) begin
      nFail++; $display("FAIL rstmid_idle reqvld got=%b want=0", io_MemReqVld); end
  endtask

  task automatic test_random(input int rounds);
    apply_reset();
    for (int r = 0; r < rounds; r++) test_traffic(3'($urandom_range(1, 7)));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_i_refill();
    test_alternation();
    test_d_writeback();
    test_io_priority();
    test_req_stall();
    test_reset_mid();
    test_alternation();
    test_random(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
